ysyx_22040750_mdu: RTL and testbench

Iterative multiply/divide unit for the RV64M instructions in the EX stage. It receives a one-cycle start pulse from the ID/EX pipeline register when a multicycle op (`alu_op_sel[13:10]`) enters EX. It drives back the `alu_output_valid` that gates ID/EX `allowout`/`valid`. The result is held until the downstream stage accepts it.

---
 rtl/ysyx_22040750_mdu_pkg.sv | 37 +++
 rtl/ysyx_22040750_mdu_if.sv | 27 ++
 rtl/ysyx_22040750_mdu_iter.sv | 30 +++
 rtl/ysyx_22040750_mdu.sv | 139 +++++++++++++
 tb/tb_ysyx_22040750_mdu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040750_mdu_pkg.sv
// Shared constants, control struct and helpers for the RV64M multiply/divide unit.
// Defining YSYX_22040750_MDU_WORD_FAST_EN lets word ops finish in 32 iterations.
package ysyx_22040750_mdu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int OP_MUL  = 0;
  localparam int OP_MULH = 1;
  localparam int OP_DIV  = 2;
  localparam int OP_REM  = 3;

  localparam logic [6:0] ITER_D = 7'd64;
  localparam logic [6:0] ITER_W = 7'd32;

`ifdef YSYX_22040750_MDU_WORD_FAST_EN
  localparam bit WORD_FAST = 1'b1;
`else
  localparam bit WORD_FAST = 1'b0;
`endif

  typedef struct packed {
    logic div_mode;
    logic sel_hi;
    logic sel_rem;
    logic word;
    logic fast;
    logic neg;
    logic special;
  } mdu_ctrl_t;

  function automatic logic [63:0] word_ext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040750_mdu_if.sv
// Request/response bundle between the ID/EX stage and the multiply/divide unit.
interface ysyx_22040750_mdu_if;
  import ysyx_22040750_mdu_pkg::*;

  logic        I_start;
  logic [3:0]  I_op_sel;
  logic [1:0]  I_alu_sext;
  logic        I_word_op;
  logic [63:0] I_op1;
  logic [63:0] I_op2;
  logic        I_allowout;
  logic        I_flush;
  logic [63:0] O_result;
  logic        O_valid;
  logic        O_busy;

  modport master (
    output I_start, I_op_sel, I_alu_sext, I_word_op, I_op1, I_op2, I_allowout, I_flush,
    input  O_result, O_valid, O_busy
  );

  modport slave (
    input  I_start, I_op_sel, I_alu_sext, I_word_op, I_op1, I_op2, I_allowout, I_flush,
    output O_result, O_valid, O_busy
  );

endinterface

// File: rtl/ysyx_22040750_mdu_iter.sv
// One combinational step of the iterative unit: shift-add multiply or restoring divide.
module ysyx_22040750_mdu_iter
  import ysyx_22040750_mdu_pkg::*;
(
  input  logic         div_mode,
  input  logic [127:0] acc_i,
  input  logic [63:0]  b_i,
  output logic [127:0] acc_o
);

  logic [64:0] sum;
  logic [64:0] shifted;
  logic [64:0] trial;

  // Divide keeps {remainder, quotient/dividend} in acc; a set trial[64] means the subtract underflowed.
  always_comb begin
    sum     = {1'b0, acc_i[127:64]} + (acc_i[0] ? {1'b0, b_i} : 65'd0);
    shifted = {acc_i[127:64], acc_i[63]};
    trial   = shifted - {1'b0, b_i};
    if (div_mode) begin
      if (trial[64])
        acc_o = {shifted[63:0], acc_i[62:0], 1'b0};
      else
        acc_o = {trial[63:0], acc_i[62:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[63:1]};
    end
  end

endmodule

// File: rtl/ysyx_22040750_mdu.sv
// RV64M iterative multiply/divide unit for the EX stage; result held until accepted.
// Word ops take 32 iterations when YSYX_22040750_MDU_WORD_FAST_EN is defined, else 64.
module ysyx_22040750_mdu
  import ysyx_22040750_mdu_pkg::*;
(
  input  logic               I_sys_clk,
  input  logic               I_rst,
  ysyx_22040750_mdu_if.slave bus
);

  logic [1:0]   state;
  logic [6:0]   cnt;
  logic [127:0] acc;
  logic [127:0] acc_nx;
  logic [127:0] acc_init;
  logic [63:0]  opb;
  logic [63:0]  result_q;
  mdu_ctrl_t    ctrl;
  mdu_ctrl_t    ctrl_nx;

  logic [63:0]  op1_x, op2_x, abs1, abs2, special_res;
  logic         s1, s2, mul_req, div_req, div_zero, div_ovf, fast;

  logic [127:0] prod, prod_s;
  logic [63:0]  qr, qr_s, res_raw, res_fin;

  // Operand preparation: word extension, magnitudes and the divide corner cases.
  always_comb begin
    op1_x = bus.I_word_op ? {{32{bus.I_alu_sext[1] & bus.I_op1[31]}}, bus.I_op1[31:0]} : bus.I_op1;
    op2_x = bus.I_word_op ? {{32{bus.I_alu_sext[0] & bus.I_op2[31]}}, bus.I_op2[31:0]} : bus.I_op2;
    s1    = bus.I_alu_sext[1] & op1_x[63];
    s2    = bus.I_alu_sext[0] & op2_x[63];
    abs1  = s1 ? (~op1_x + 64'd1) : op1_x;
    abs2  = s2 ? (~op2_x + 64'd1) : op2_x;

    mul_req  = bus.I_op_sel[OP_MUL] | bus.I_op_sel[OP_MULH];
    div_req  = bus.I_op_sel[OP_DIV] | bus.I_op_sel[OP_REM];
    fast     = WORD_FAST & bus.I_word_op;
    div_zero = (op2_x == 64'd0);
    if (bus.I_word_op)
      div_ovf = (bus.I_alu_sext == 2'b11) && (op1_x[31:0] == 32'h8000_0000) &&
                (op2_x[31:0] == 32'hFFFF_FFFF);
    else
      div_ovf = (bus.I_alu_sext == 2'b11) && (op1_x == 64'h8000_0000_0000_0000) &&
                (op2_x == 64'hFFFF_FFFF_FFFF_FFFF);

    if (div_zero)
      special_res = bus.I_op_sel[OP_REM] ? op1_x : 64'hFFFF_FFFF_FFFF_FFFF;
    else
      special_res = bus.I_op_sel[OP_REM] ? 64'd0 : op1_x;
    if (bus.I_word_op)
      special_res = word_ext(special_res[31:0]);

    ctrl_nx.div_mode = div_req;
    ctrl_nx.sel_hi   = bus.I_op_sel[OP_MULH];
    ctrl_nx.sel_rem  = bus.I_op_sel[OP_REM];
    ctrl_nx.word     = bus.I_word_op;
    ctrl_nx.fast     = fast;
    ctrl_nx.neg      = bus.I_op_sel[OP_REM] ? s1 : (s1 ^ s2);
    ctrl_nx.special  = div_req & (div_zero | div_ovf);

    // Fast word divide parks the 32-bit dividend at the top of the quotient half.
    if (ctrl_nx.special)
      acc_init = {64'd0, special_res};
    else if (div_req && fast)
      acc_init = {64'd0, abs1[31:0], 32'd0};
    else
      acc_init = {64'd0, abs1};
  end

  ysyx_22040750_mdu_iter u_iter (
    .div_mode (ctrl.div_mode),
    .acc_i    (acc),
    .b_i      (opb),
    .acc_o    (acc_nx)
  );

  // Product is negated over the full 128 bits so mulh sees the correct high half.
  always_comb begin
    prod    = ctrl.fast ? {32'd0, acc_nx[127:32]} : acc_nx;
    prod_s  = ctrl.neg ? (~prod + 128'd1) : prod;
    qr      = ctrl.sel_rem ? acc_nx[127:64] : acc_nx[63:0];
    qr_s    = ctrl.neg ? (~qr + 64'd1) : qr;
    if (ctrl.div_mode)
      res_raw = qr_s;
    else if (ctrl.sel_hi && !ctrl.word)
      res_raw = prod_s[127:64];
    else
      res_raw = prod_s[63:0];
    res_fin = ctrl.word ? word_ext(res_raw[31:0]) : res_raw;
  end

  // Special cases spend a single CALC cycle replaying the value parked in acc.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state    <= ST_IDLE;
      cnt      <= 7'd0;
      acc      <= 128'd0;
      opb      <= 64'd0;
      ctrl     <= '0;
      result_q <= 64'd0;
    end else if (bus.I_flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.I_start && (mul_req || div_req)) begin
            ctrl  <= ctrl_nx;
            acc   <= acc_init;
            opb   <= abs2;
            state <= ST_CALC;
            if (ctrl_nx.special)
              cnt <= 7'd1;
            else
              cnt <= fast ? ITER_W : ITER_D;
          end
        end
        ST_CALC: begin
          acc <= acc_nx;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            result_q <= ctrl.special ? acc[63:0] : res_fin;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.I_allowout)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.O_result = result_q;
  assign bus.O_valid  = (state == ST_DONE);
  assign bus.O_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22040750_mdu.sv
// Directed self-checking bench for the RV64M multiply/divide unit.
module tb_ysyx_22040750_mdu;

`ifdef YSYX_22040750_MDU_WORD_FAST_EN
  localparam logic [7:0] LAT_W = 8'd32;
`else
  localparam logic [7:0] LAT_W = 8'd64;
`endif

  typedef struct packed {
    logic [3:0]  sel;
    logic [1:0]  sext;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_22040750_mdu_if bus ();

  ysyx_22040750_mdu dut (
    .I_sys_clk (clk),
    .I_rst     (rst),
    .bus       (bus)
  );

  task automatic run_op(input logic [3:0] sel, input logic [1:0] sext, input logic w,
                        input logic [63:0] a, input logic [63:0] b, output int lat);
    bus.I_op_sel   = sel;
    bus.I_alu_sext = sext;
    bus.I_word_op  = w;
    bus.I_op1      = a;
    bus.I_op2      = b;
    bus.I_start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.I_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.O_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic accept();
    bus.I_allowout = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.I_allowout = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.I_start    = 1'b0;
    bus.I_op_sel   = 4'd0;
    bus.I_alu_sext = 2'd0;
    bus.I_word_op  = 1'b0;
    bus.I_op1      = 64'd0;
    bus.I_op2      = 64'd0;
    bus.I_allowout = 1'b0;
    bus.I_flush    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.O_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b, want 0", bus.O_valid); end
    n_cmp++;
    if (bus.O_busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b, want 0", bus.O_busy); end
    n_cmp++;
    if (bus.O_result !== 64'd0) begin n_err++; $display("[TB] FAIL reset_result: got %h, want 0", bus.O_result); end
  endtask

  task automatic test_mul();
    vec_t v [4];
    int   lat;
    v[0] = '{4'b0001, 2'b11, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 8'd64};
    v[1] = '{4'b0010, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 8'd64};
    v[2] = '{4'b0010, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'd64};
    v[3] = '{4'b0001, 2'b11, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, LAT_W};
    for (int i = 0; i < 4; i++) begin
      run_op(v[i].sel, v[i].sext, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++;
      if (lat !== int'(v[i].lat)) begin n_err++; $display("[TB] FAIL mul[%0d]_latency: got %0d, want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus.O_result !== v[i].exp) begin n_err++; $display("[TB] FAIL mul[%0d]_result: got %h, want %h", i, bus.O_result, v[i].exp); end
      accept();
    end
  endtask

  task automatic test_div();
    vec_t v [3];
    int   lat;
    v[0] = '{4'b0100, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd64};
    v[1] = '{4'b1000, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd64};
    v[2] = '{4'b0100, 2'b11, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_W};
    for (int i = 0; i < 3; i++) begin
      run_op(v[i].sel, v[i].sext, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++;
      if (lat !== int'(v[i].lat)) begin n_err++; $display("[TB] FAIL div[%0d]_latency: got %0d, want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus.O_result !== v[i].exp) begin n_err++; $display("[TB] FAIL div[%0d]_result: got %h, want %h", i, bus.O_result, v[i].exp); end
      accept();
    end
  endtask

  task automatic test_special();
    vec_t v [5];
    int   lat;
    v[0] = '{4'b0100, 2'b00, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd1};
    v[1] = '{4'b1000, 2'b00, 1'b0, 64'h1234, 64'd0, 64'h1234, 8'd1};
    v[2] = '{4'b0100, 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd1};
    v[3] = '{4'b1000, 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd1};
    v[4] = '{4'b0100, 2'b11, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd1};
    for (int i = 0; i < 5; i++) begin
      run_op(v[i].sel, v[i].sext, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++;
      if (lat !== int'(v[i].lat)) begin n_err++; $display("[TB] FAIL special[%0d]_latency: got %0d, want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus.O_result !== v[i].exp) begin n_err++; $display("[TB] FAIL special[%0d]_result: got %h, want %h", i, bus.O_result, v[i].exp); end
      accept();
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [2];
    int   lat;
    v[0] = '{4'b0100, 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 8'd64};
    v[1] = '{4'b1000, 2'b00, 1'b0, 64'd100, 64'd7, 64'd2, 8'd64};
    for (int i = 0; i < 2; i++) begin
      run_op(v[i].sel, v[i].sext, v[i].w, v[i].a, v[i].b, lat);
      n_cmp++;
      if (lat !== int'(v[i].lat)) begin n_err++; $display("[TB] FAIL b2b[%0d]_latency: got %0d, want %0d", i, lat, v[i].lat); end
      n_cmp++;
      if (bus.O_result !== v[i].exp) begin n_err++; $display("[TB] FAIL b2b[%0d]_result: got %h, want %h", i, bus.O_result, v[i].exp); end
      accept();
    end
  endtask

  task automatic test_handshake();
    int lat;
    run_op(4'b0001, 2'b11, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, lat);
    n_cmp++;
    if (lat !== 64) begin n_err++; $display("[TB] FAIL hs_latency: got %0d, want 64", lat); end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (bus.O_valid !== 1'b1) begin n_err++; $display("[TB] FAIL hs_hold_valid[%0d]: got %b, want 1", c, bus.O_valid); end
      n_cmp++;
      if (bus.O_result !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_err++; $display("[TB] FAIL hs_hold_result[%0d]: got %h, want fffffffffffffff1", c, bus.O_result); end
      bus.I_start = (c == 4);
      if (c == 4) begin
        bus.I_op_sel = 4'b0100; bus.I_alu_sext = 2'b00; bus.I_word_op = 1'b0;
        bus.I_op1 = 64'h1234; bus.I_op2 = 64'd0;
      end
      @(negedge clk);
    end
    bus.I_start = 1'b1;
    accept();
    bus.I_start = 1'b0;
    n_cmp++;
    if (bus.O_valid !== 1'b0) begin n_err++; $display("[TB] FAIL hs_accept_valid: got %b, want 0", bus.O_valid); end
    n_cmp++;
    if (bus.O_busy !== 1'b0) begin n_err++; $display("[TB] FAIL hs_accept_busy: got %b, want 0", bus.O_busy); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.O_valid !== 1'b0) begin n_err++; $display("[TB] FAIL hs_start_ignored: got valid %b, want 0", bus.O_valid); end
  endtask

  task automatic test_flush();
    int   lat;
    logic seen;
    bus.I_op_sel = 4'b0001; bus.I_alu_sext = 2'b00; bus.I_word_op = 1'b0;
    bus.I_op1 = 64'd6; bus.I_op2 = 64'd7;
    bus.I_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.I_start = 1'b0;
    repeat (19) @(negedge clk);
    n_cmp++;
    if (bus.O_busy !== 1'b1) begin n_err++; $display("[TB] FAIL flush_busy_before: got %b, want 1", bus.O_busy); end
    bus.I_flush = 1'b1;
    bus.I_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.I_flush = 1'b0;
    bus.I_start = 1'b0;
    n_cmp++;
    if (bus.O_busy !== 1'b0) begin n_err++; $display("[TB] FAIL flush_busy_after: got %b, want 0", bus.O_busy); end
    n_cmp++;
    if (bus.O_valid !== 1'b0) begin n_err++; $display("[TB] FAIL flush_valid_after: got %b, want 0", bus.O_valid); end
    n_cmp++;
    if (bus.O_result !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_err++; $display("[TB] FAIL flush_result_kept: got %h, want fffffffffffffff1", bus.O_result); end
    seen = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (bus.O_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("[TB] FAIL flush_no_valid: got %b, want 0", seen); end
    run_op(4'b0001, 2'b00, 1'b0, 64'd6, 64'd7, lat);
    n_cmp++;
    if (lat !== 64) begin n_err++; $display("[TB] FAIL flush_next_latency: got %0d, want 64", lat); end
    n_cmp++;
    if (bus.O_result !== 64'd42) begin n_err++; $display("[TB] FAIL flush_next_result: got %h, want 2a", bus.O_result); end
    accept();
  endtask

  initial begin
    $display("[TB] starting mdu bench, word latency %0d", LAT_W);
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_handshake();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
